// File: rtl/bcd_convert_arbiter_if.sv
// bcd_convert_arbiter_if: request/result bundle between value sources and the shared BCD converter
interface bcd_convert_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int BIN_W   = 14,
  parameter int DIGITS  = 4
);
  localparam int ID_W = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*BIN_W-1:0] bin_in;
  logic                     busy;
  logic [ID_W-1:0]          grant_id;
  logic                     done;
  logic [4*DIGITS-1:0]      bcd_out;
  logic                     ovf;
  modport master (output req, bin_in, input busy, grant_id, done, bcd_out, ovf);
  modport slave  (input req, bin_in, output busy, grant_id, done, bcd_out, ovf);
endinterface

// File: rtl/bcd_convert_arbiter.sv
// bcd_convert_arbiter: round-robin shared iterative binary-to-BCD (double-dabble) converter
module bcd_convert_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int BIN_W   = 14,
  parameter int DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  bcd_convert_arbiter_if.slave  bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int ACC_W = 4 * DIGITS;
  localparam longint LIMIT = longint'(10) ** DIGITS;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t             state_q, state_d;
  logic [BIN_W-1:0]   sh_q, sh_d;
  logic [ACC_W-1:0]   acc_q, acc_d, adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    gid_q, gid_d, last_q, last_d, pick;
  logic               ovfl_q, ovfl_d, ovf_q, ovf_d, done_q, done_d, found;
  logic [ACC_W-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]   op;
  int                 j;
  // round-robin search upward from the requester after the last one served
  always_comb begin
    found = 1'b0;
    pick  = '0;
    j     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(last_q) + k) % NUM_REQ;
      if (!found && bus.req[j]) begin
        found = 1'b1;
        pick  = ID_W'(j);
      end
    end
  end
  assign op = bus.bin_in[pick*BIN_W +: BIN_W];
  // add-3 correction of every accumulator digit that is 5 or more
  always_comb begin
    adj = acc_q;
    for (int k = 0; k < DIGITS; k++)
      adj[4*k +: 4] = (acc_q[4*k +: 4] >= 4'd5) ? acc_q[4*k +: 4] + 4'd3 : acc_q[4*k +: 4];
  end
  // next-state and datapath updates for grant, shift iterations and result load
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    gid_d   = gid_q;
    last_d  = last_q;
    ovfl_d  = ovfl_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        state_d = SHIFT;
        sh_d    = op;
        acc_d   = '0;
        cnt_d   = '0;
        gid_d   = pick;
        ovfl_d  = longint'(op) >= LIMIT;
      end
      SHIFT: begin
        acc_d   = {adj[ACC_W-2:0], sh_q[BIN_W-1]};
        sh_d    = sh_q << 1;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CNT_W'(BIN_W - 1)) ? DONE : SHIFT;
      end
      DONE: begin
        bcd_d   = ovfl_q ? {DIGITS{4'h9}} : acc_q;
        ovf_d   = ovfl_q;
        done_d  = 1'b1;
        last_d  = gid_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset drops any conversion in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      gid_q   <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
      ovfl_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      ovfl_q  <= ovfl_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end
  assign bus.busy     = state_q != IDLE;
  assign bus.grant_id = gid_q;
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.ovf      = ovf_q;
endmodule
